word_alert_ctrl: RTL and testbench

- Downstream consumer of the keyword DP matcher (DP_main) result stream.
- Confirms a detection after HITS consecutive positive result_dv strobes, then drives the piezo with a gated square-wave tone for a fixed time, then enforces a refractory holdoff.
- Latches the DP score and length of the confirming frame and shows them bit-serially on LEDs.
- Replaces the ad-hoc beep/LED logic in the top level.

---
 rtl/word_alert_ctrl_pkg.sv | 26 ++
 rtl/word_alert_ctrl_if.sv | 22 ++
 rtl/word_alert_ctrl_led_serializer.sv | 81 ++++++++
 rtl/word_alert_ctrl.sv | 174 +++++++++++++++++
 tb/tb_word_alert_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/word_alert_ctrl_pkg.sv
// word_alert_ctrl_pkg
// Shared types and default timing for the keyword alert controller.
// Contents: alert FSM state enum, 50 MHz default timing constants
// (4 kHz tone, 1 s beep, 0.5 s holdoff, 20 bit/s serial LEDs) and a
// counter-width helper.
package word_alert_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BEEP,
        HOLDOFF
    } state_t;

    localparam int unsigned CLK_HZ               = 50_000_000;
    localparam int unsigned TONE_HZ              = 4_000;
    localparam int unsigned DEF_TONE_HALF        = CLK_HZ / (2 * TONE_HZ);
    localparam int unsigned DEF_BEEP_CYCLES      = CLK_HZ;
    localparam int unsigned DEF_HOLDOFF_CYCLES   = CLK_HZ / 2;
    localparam int unsigned DEF_SER_DIV          = CLK_HZ / 20;

    // Bits needed for a counter running 0..n-1, never less than one.
    function automatic int unsigned cw(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/word_alert_ctrl_if.sv
// word_alert_ctrl_if
// DP matcher result stream as seen by the alert controller.
// Signals:
//   result_dv  one-cycle strobe, result valid
//   result     1 = frame matched keyword
//   scr_i      DP score (SCR_W bits), valid with result_dv
//   len_i      DP path length (LEN_W bits), valid with result_dv
//   vad_i      voice activity from the MFCC front end
// Modports: master (matcher side, drives), slave (alert controller, receives).
interface word_alert_ctrl_if #(
    parameter int unsigned SCR_W = 24,
    parameter int unsigned LEN_W = 7
);
    logic             result_dv;
    logic             result;
    logic [SCR_W-1:0] scr_i;
    logic [LEN_W-1:0] len_i;
    logic             vad_i;

    modport master (output result_dv, result, scr_i, len_i, vad_i);
    modport slave  (input  result_dv, result, scr_i, len_i, vad_i);
endinterface

// File: rtl/word_alert_ctrl_led_serializer.sv
// led_serializer
// Free-running bit-serial LED display of a W-bit word.
// Frame: one high start slot, W data slots MSB-first, two low slots;
// every slot lasts SER_DIV clk cycles. data is sampled at each frame start.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high
//   data   word to display
//   ser    serial LED output (0 during reset)
module led_serializer
    import word_alert_ctrl_pkg::*;
#(
    parameter int unsigned W       = 8,
    parameter int unsigned SER_DIV = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] data,
    output logic         ser
);

    localparam int unsigned SLOTS = W + 3;
    localparam int unsigned SW    = cw(SLOTS);
    localparam int unsigned DW    = cw(SER_DIV);

    localparam logic [SW-1:0] SLOT_LAST = SW'(SLOTS - 1);
    localparam logic [SW-1:0] SLOT_DMAX = SW'(W);
    localparam logic [DW-1:0] DIV_LAST  = DW'(SER_DIV - 1);

    logic [DW-1:0] div_q, div_n;
    logic [SW-1:0] slot_q, slot_n;
    logic [W-1:0]  sh_q, sh_n;
    logic          ser_q, ser_n;

    always_comb begin
        div_n  = div_q;
        slot_n = slot_q;
        sh_n   = sh_q;
        if (div_q == DIV_LAST) begin
            div_n = '0;
            if (slot_q == SLOT_LAST) begin
                slot_n = '0;
                sh_n   = data;
            end else begin
                slot_n = slot_q + 1'b1;
                if (slot_q != '0 && slot_q <= SLOT_DMAX) begin
                    sh_n = sh_q << 1;
                end
            end
        end else begin
            div_n = div_q + 1'b1;
        end
        // Output is registered from the next slot so reset forces it low.
        if (slot_n == '0) begin
            ser_n = 1'b1;
        end else if (slot_n <= SLOT_DMAX) begin
            ser_n = sh_n[W-1];
        end else begin
            ser_n = 1'b0;
        end
    end

    // Reset parks the counters on the last tail cycle, so the first edge
    // after release starts a full-length frame and loads data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q  <= DIV_LAST;
            slot_q <= SLOT_LAST;
            sh_q   <= '0;
            ser_q  <= 1'b0;
        end else begin
            div_q  <= div_n;
            slot_q <= slot_n;
            sh_q   <= sh_n;
            ser_q  <= ser_n;
        end
    end

    assign ser = ser_q;

endmodule

// File: rtl/word_alert_ctrl.sv
// word_alert_ctrl
// Consumer of the DP matcher result stream: confirms a keyword after HITS
// consecutive positive results, beeps the piezo with a gated square wave
// for BEEP_CYCLES, then holds off for HOLDOFF_CYCLES. Score and length of
// the confirming frame are latched and shown bit-serially on two LEDs.
// Build option: WORD_ALERT_VAD_GATE_EN -- when defined, a result strobe
// with vad_i low clears the hit counter (only voiced hits count);
// otherwise vad_i is ignored.
// Ports:
//   clk        system clock (50 MHz)
//   reset      asynchronous, active-high
//   res        result stream (word_alert_ctrl_if.slave)
//   beep       piezo drive
//   led_det    high while beeping
//   led_scr    serial latched score
//   led_len    serial latched length
//   det_count  confirmed detections, saturating at 255
//   busy       high while beeping or holding off
module word_alert_ctrl
    import word_alert_ctrl_pkg::*;
#(
    parameter int unsigned HITS           = 2,
    parameter int unsigned TONE_HALF      = DEF_TONE_HALF,
    parameter int unsigned BEEP_CYCLES    = DEF_BEEP_CYCLES,
    parameter int unsigned HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
    parameter int unsigned SER_DIV        = DEF_SER_DIV,
    parameter int unsigned SCR_W          = 24,
    parameter int unsigned LEN_W          = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    word_alert_ctrl_if.slave         res,
    output logic                     beep,
    output logic                     led_det,
    output logic                     led_scr,
    output logic                     led_len,
    output logic [7:0]               det_count,
    output logic                     busy
);

    localparam int unsigned TMAX = (BEEP_CYCLES > HOLDOFF_CYCLES) ? BEEP_CYCLES : HOLDOFF_CYCLES;
    localparam int unsigned TW   = cw(TMAX);
    localparam int unsigned THW  = cw(TONE_HALF);

    localparam logic [TW-1:0]  BEEP_LAST = TW'(BEEP_CYCLES - 1);
    localparam logic [TW-1:0]  HOLD_LAST = TW'(HOLDOFF_CYCLES - 1);
    localparam logic [THW-1:0] TONE_LAST = THW'(TONE_HALF - 1);
    localparam logic [3:0]     HIT_LAST  = 4'(HITS - 1);

    state_t           state, state_n;
    logic [TW-1:0]    tmr, tmr_n;
    logic [THW-1:0]   tone, tone_n;
    logic             beep_q, beep_n;
    logic [3:0]       hit, hit_n;
    logic [7:0]       det, det_n;
    logic [SCR_W-1:0] scr_lat, scr_lat_n;
    logic [LEN_W-1:0] len_lat, len_lat_n;
    logic             hit_ok;

`ifdef WORD_ALERT_VAD_GATE_EN
    assign hit_ok = res.result & res.vad_i;
`else
    logic unused_vad;
    assign unused_vad = res.vad_i;
    assign hit_ok     = res.result;
`endif

    always_comb begin
        state_n   = state;
        tmr_n     = tmr;
        tone_n    = tone;
        beep_n    = beep_q;
        hit_n     = hit;
        det_n     = det;
        scr_lat_n = scr_lat;
        len_lat_n = len_lat;
        case (state)
            IDLE: begin
                tmr_n  = '0;
                tone_n = '0;
                beep_n = 1'b0;
                if (res.result_dv) begin
                    if (hit_ok) begin
                        if (hit == HIT_LAST) begin
                            scr_lat_n = res.scr_i;
                            len_lat_n = res.len_i;
                            if (det != 8'hFF) begin
                                det_n = det + 8'd1;
                            end
                            hit_n   = '0;
                            state_n = BEEP;
                        end else begin
                            hit_n = hit + 4'd1;
                        end
                    end else begin
                        hit_n = '0;
                    end
                end
            end
            BEEP: begin
                if (tmr == BEEP_LAST) begin
                    state_n = HOLDOFF;
                    tmr_n   = '0;
                    tone_n  = '0;
                    beep_n  = 1'b0;
                end else begin
                    tmr_n = tmr + 1'b1;
                    if (tone == TONE_LAST) begin
                        tone_n = '0;
                        beep_n = ~beep_q;
                    end else begin
                        tone_n = tone + 1'b1;
                    end
                end
            end
            HOLDOFF: begin
                beep_n = 1'b0;
                if (tmr == HOLD_LAST) begin
                    state_n = IDLE;
                    tmr_n   = '0;
                    hit_n   = '0;
                end else begin
                    tmr_n = tmr + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                beep_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            tmr     <= '0;
            tone    <= '0;
            beep_q  <= 1'b0;
            hit     <= '0;
            det     <= '0;
            scr_lat <= '0;
            len_lat <= '0;
        end else begin
            state   <= state_n;
            tmr     <= tmr_n;
            tone    <= tone_n;
            beep_q  <= beep_n;
            hit     <= hit_n;
            det     <= det_n;
            scr_lat <= scr_lat_n;
            len_lat <= len_lat_n;
        end
    end

    assign beep      = beep_q;
    assign led_det   = (state == BEEP);
    assign busy      = (state != IDLE);
    assign det_count = det;

    led_serializer #(.W(SCR_W), .SER_DIV(SER_DIV)) u_scr_ser (
        .clk   (clk),
        .reset (reset),
        .data  (scr_lat),
        .ser   (led_scr)
    );

    led_serializer #(.W(LEN_W), .SER_DIV(SER_DIV)) u_len_ser (
        .clk   (clk),
        .reset (reset),
        .data  (len_lat),
        .ser   (led_len)
    );

endmodule

// File: tb/tb_word_alert_ctrl.sv
// tb_word_alert_ctrl
// Directed bench for word_alert_ctrl with short timing:
// HITS=2, TONE_HALF=4, BEEP_CYCLES=40, HOLDOFF_CYCLES=20, SER_DIV=2.
// Honours WORD_ALERT_VAD_GATE_EN for the voice-activity expectations.
module tb_word_alert_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       beep, led_det, led_scr, led_len, busy;
    logic [7:0] det_count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc;

    logic [26:0] sframe;
    logic [9:0]  lframe;

    always #5 clk = ~clk;

    word_alert_ctrl_if #(.SCR_W(24), .LEN_W(7)) res ();

    word_alert_ctrl #(
        .HITS           (2),
        .TONE_HALF      (4),
        .BEEP_CYCLES    (40),
        .HOLDOFF_CYCLES (20),
        .SER_DIV        (2),
        .SCR_W          (24),
        .LEN_W          (7)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .res       (res.slave),
        .beep      (beep),
        .led_det   (led_det),
        .led_scr   (led_scr),
        .led_len   (led_len),
        .det_count (det_count),
        .busy      (busy)
    );

    // Edges since reset release: after edge k, cyc == k.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic r, input logic [23:0] s, input logic [6:0] l, input logic v);
        res.result_dv = 1'b1;
        res.result    = r;
        res.scr_i     = s;
        res.len_i     = l;
        res.vad_i     = v;
        tick();
        res.result_dv = 1'b0;
        res.result    = 1'b0;
        res.vad_i     = 1'b1;
    endtask

    // Follows one BEEP+HOLDOFF episode edge by edge after the entry edge;
    // optionally injects positive strobes during BEEP (edge 10) and HOLDOFF (edge 50).
    task automatic burst(input string tag, input bit inject);
        for (int k = 1; k <= 60; k++) begin
            res.result_dv = inject && (k == 10 || k == 50);
            res.result    = res.result_dv;
            tick();
            res.result_dv = 1'b0;
            res.result    = 1'b0;
            check({tag, "_beep"},    32'(beep),    (k < 40) ? 32'((k / 4) % 2) : 32'd0);
            check({tag, "_led_det"}, 32'(led_det), (k < 40) ? 32'd1 : 32'd0);
            check({tag, "_busy"},    32'(busy),    (k < 60) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        sframe = {1'b1, 24'h00A5A5, 2'b00};
        lframe = {1'b1, 7'd37, 2'b00};
        reset = 1'b1;
        res.result_dv = 1'b0;
        res.result    = 1'b0;
        res.scr_i     = '0;
        res.len_i     = '0;
        res.vad_i     = 1'b1;
        repeat (3) tick();
        check("rst_beep",  32'(beep),      32'd0);
        check("rst_det",   32'(led_det),   32'd0);
        check("rst_scr",   32'(led_scr),   32'd0);
        check("rst_len",   32'(led_len),   32'd0);
        check("rst_count", 32'(det_count), 32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        reset = 1'b0;
        tick();

        // 1: two positive strobes confirm
        strobe(1'b1, 24'h00A5A5, 7'd37, 1'b1);
        check("s1_first_busy",  32'(busy),      32'd0);
        check("s1_first_count", 32'(det_count), 32'd0);
        strobe(1'b1, 24'h00A5A5, 7'd37, 1'b1);
        check("s1_led_det", 32'(led_det),   32'd1);
        check("s1_busy",    32'(busy),      32'd1);
        check("s1_count",   32'(det_count), 32'd1);
        check("s1_beep0",   32'(beep),      32'd0);
        burst("s1", 1'b0);

        // 5: serial score frame, then length frame
        for (int i = 0; i < 54 && ((cyc - 1) % 54) != 0; i++) tick();
        check("s5_scr_sync", 32'(((cyc - 1) % 54) == 0), 32'd1);
        for (int p = 0; p < 54; p++) begin
            check("s5_led_scr", 32'(led_scr), 32'(sframe[26 - p / 2]));
            tick();
        end
        for (int i = 0; i < 20 && ((cyc - 1) % 20) != 0; i++) tick();
        check("s5_len_sync", 32'(((cyc - 1) % 20) == 0), 32'd1);
        for (int p = 0; p < 20; p++) begin
            check("s5_led_len", 32'(led_len), 32'(lframe[9 - p / 2]));
            tick();
        end

        // 2: 1,0,1 does not confirm; one more 1 does
        strobe(1'b1, 24'h000001, 7'd1, 1'b1);
        strobe(1'b0, 24'h000002, 7'd2, 1'b1);
        strobe(1'b1, 24'h000003, 7'd3, 1'b1);
        check("s2_no_det_busy",  32'(busy),      32'd0);
        check("s2_no_det_count", 32'(det_count), 32'd1);
        strobe(1'b1, 24'h000004, 7'd4, 1'b1);
        check("s2_det_busy",  32'(busy),      32'd1);
        check("s2_det_count", 32'(det_count), 32'd2);

        // 3: strobes while busy ignored; strobe on return cycle counts
        burst("s3", 1'b1);
        check("s3_count_kept", 32'(det_count), 32'd2);
        strobe(1'b1, 24'h000005, 7'd5, 1'b1);
        check("s3_return_one_hit", 32'(busy), 32'd0);
        strobe(1'b1, 24'h000006, 7'd6, 1'b1);
        check("s3_confirm_busy",  32'(busy),      32'd1);
        check("s3_confirm_count", 32'(det_count), 32'd3);

        // 4: reset during BEEP while tone is high
        repeat (6) tick();
        check("s4_beep_high", 32'(beep), 32'd1);
        reset = 1'b1;
        #1;
        check("s4_beep",   32'(beep),      32'd0);
        check("s4_det",    32'(led_det),   32'd0);
        check("s4_busy",   32'(busy),      32'd0);
        check("s4_count",  32'(det_count), 32'd0);
        check("s4_scr",    32'(led_scr),   32'd0);
        check("s4_len",    32'(led_len),   32'd0);
        repeat (2) tick();
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            check("s4_post_beep", 32'(beep), 32'd0);
            check("s4_post_busy", 32'(busy), 32'd0);
        end

        // 6: voice activity gating
        strobe(1'b1, 24'h000007, 7'd7, 1'b0);
        strobe(1'b1, 24'h000007, 7'd7, 1'b0);
`ifdef WORD_ALERT_VAD_GATE_EN
        check("s6_unvoiced_busy", 32'(busy), 32'd0);
        strobe(1'b1, 24'h000008, 7'd8, 1'b1);
        strobe(1'b1, 24'h000008, 7'd8, 1'b1);
        check("s6_voiced_busy", 32'(busy), 32'd1);
`else
        check("s6_ungated_busy", 32'(busy), 32'd1);
`endif
        check("s6_count", 32'(det_count), 32'd1);
        repeat (60) tick();
        check("s6_idle", 32'(busy), 32'd0);

        // det_count saturation
        for (int i = 0; i < 300 && det_count != 8'd254; i++) begin
            strobe(1'b1, 24'h000009, 7'd9, 1'b1);
            strobe(1'b1, 24'h000009, 7'd9, 1'b1);
            repeat (60) tick();
        end
        check("sat_254", 32'(det_count), 32'd254);
        strobe(1'b1, 24'h00000A, 7'd10, 1'b1);
        strobe(1'b1, 24'h00000A, 7'd10, 1'b1);
        check("sat_255", 32'(det_count), 32'd255);
        repeat (60) tick();
        strobe(1'b1, 24'h00000B, 7'd11, 1'b1);
        strobe(1'b1, 24'h00000B, 7'd11, 1'b1);
        check("sat_hold_det",   32'(led_det),   32'd1);
        check("sat_hold_count", 32'(det_count), 32'd255);
        repeat (60) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
